// File: rtl/game_pkg.sv
// Shared flash/game constants and the sprite loader state type.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

   localparam logic [7:0] FLASH_CMD_READ = 8'h03;
   localparam int unsigned FLASH_ADDR_W = 24;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_WRITE,
      ST_FINISH,
      ST_ERROR
   } loader_state_t;

endpackage

// File: rtl/flash_sprite_loader_if.sv
// Single-byte start/cmd/addr handshake between a requester and pmod_sf3.
// Latency: n/a (wiring only); fl_done is a one-cycle pulse per started transfer.
// Backpressure: requester must hold fl_start low while fl_busy is high.
//
// Ports (master = requester, slave = flash controller):
//   fl_start, fl_cmd, fl_addr, fl_data_in  master -> slave
//   fl_data_out, fl_busy, fl_done          slave  -> master
interface flash_sprite_loader_if;
   import game_pkg::*;

   logic                    fl_start;
   logic [7:0]              fl_cmd;
   logic [FLASH_ADDR_W-1:0] fl_addr;
   logic [7:0]              fl_data_in;
   logic [7:0]              fl_data_out;
   logic                    fl_busy;
   logic                    fl_done;

   modport master (
      output fl_start, fl_cmd, fl_addr, fl_data_in,
      input  fl_data_out, fl_busy, fl_done
   );

   modport slave (
      input  fl_start, fl_cmd, fl_addr, fl_data_in,
      output fl_data_out, fl_busy, fl_done
   );

endinterface

// File: rtl/flash_sprite_loader.sv
// Copies NUM_BYTES consecutive flash bytes into a sprite/tile RAM via pmod_sf3.
// Latency: 2 + flash read latency cycles per byte; load_done one cycle after the last write.
// Backpressure: fl_start is withheld while fl_busy is high; a missing fl_done times out to load_err.
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   load_req, load_addr      start a load from flash address load_addr (ignored unless idle)
//   abort                    cancel an in-progress load without done/err
//   fl                       flash controller handshake (master side)
//   wr_en, wr_addr, wr_data  RAM write port
//   loading, load_done, load_err, bytes_loaded   status
module flash_sprite_loader
   import game_pkg::*;
#(
   parameter int unsigned NUM_BYTES   = 1024,
   parameter int unsigned ADDR_W      = 10,
   parameter logic [7:0]  READ_CMD    = FLASH_CMD_READ,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load_req,
   input  logic [FLASH_ADDR_W-1:0] load_addr,
   input  logic                    abort,
   flash_sprite_loader_if.master   fl,
   output logic                    wr_en,
   output logic [ADDR_W-1:0]       wr_addr,
   output logic [7:0]              wr_data,
   output logic                    loading,
   output logic                    load_done,
   output logic                    load_err,
   output logic [ADDR_W:0]         bytes_loaded
);

   localparam int unsigned TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   // The counter holds k during the k-th WAIT cycle, so the final permitted
   // cycle is TIMEOUT_CYC-1; error is flagged on the transition out of it.
   localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYC - 1);
   localparam logic [ADDR_W:0]   LAST    = (ADDR_W + 1)'(NUM_BYTES);

   loader_state_t           state;
   logic [FLASH_ADDR_W-1:0] base;
   logic [ADDR_W:0]         idx;
   logic [TO_W-1:0]         tcnt;
   logic                    fl_start_q;
   logic [FLASH_ADDR_W-1:0] fl_addr_q;

   logic [ADDR_W:0]         idx_nxt;
   logic [FLASH_ADDR_W-1:0] addr_nxt;

   // Address of the next byte; the 24-bit add wraps FFFFFF -> 000000.
   assign idx_nxt  = idx + 1'b1;
   assign addr_nxt = base + FLASH_ADDR_W'(idx_nxt);

   assign fl.fl_start   = fl_start_q;
   assign fl.fl_cmd     = READ_CMD;
   assign fl.fl_addr    = fl_addr_q;
   assign fl.fl_data_in = 8'h00;

   // bytes_loaded always equals the write index: both advance once per write.
   assign bytes_loaded  = idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         base       <= '0;
         idx        <= '0;
         tcnt       <= '0;
         fl_start_q <= 1'b0;
         fl_addr_q  <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         loading    <= 1'b0;
         load_done  <= 1'b0;
         load_err   <= 1'b0;
      end else begin
         // Pulse outputs default low every cycle.
         fl_start_q <= 1'b0;
         wr_en      <= 1'b0;
         load_done  <= 1'b0;

         case (state)
            ST_IDLE: begin
               // Stray fl_done pulses from abandoned transfers land here and are dropped.
               if (load_req) begin
                  base      <= load_addr;
                  fl_addr_q <= load_addr;
                  idx       <= '0;
                  load_err  <= 1'b0;
                  loading   <= 1'b1;
                  state     <= ST_ISSUE;
               end
            end

            ST_ISSUE: begin
               if (abort) begin
                  loading <= 1'b0;
                  state   <= ST_IDLE;
               end else if (!fl.fl_busy) begin
                  fl_start_q <= 1'b1;
                  tcnt       <= '0;
                  state      <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               // abort beats fl_done; fl_done beats the timeout.
               if (abort) begin
                  loading <= 1'b0;
                  state   <= ST_IDLE;
               end else if (fl.fl_done) begin
                  wr_en   <= 1'b1;
                  wr_addr <= idx[ADDR_W-1:0];
                  wr_data <= fl.fl_data_out;
                  state   <= ST_WRITE;
               end else if (tcnt == TO_LAST) begin
                  load_err <= 1'b1;
                  loading  <= 1'b0;
                  state    <= ST_ERROR;
               end else begin
                  tcnt <= tcnt + 1'b1;
               end
            end

            ST_WRITE: begin
               // The write strobe is already on the port this cycle, so it is
               // counted even when abort arrives now.
               idx <= idx_nxt;
               if (abort) begin
                  loading <= 1'b0;
                  state   <= ST_IDLE;
               end else if (idx_nxt == LAST) begin
                  load_done <= 1'b1;
                  loading   <= 1'b0;
                  state     <= ST_FINISH;
               end else begin
                  fl_addr_q <= addr_nxt;
                  state     <= ST_ISSUE;
               end
            end

            ST_FINISH: state <= ST_IDLE;

            ST_ERROR:  state <= ST_IDLE;

            default:   state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_sprite_loader.sv
// Directed + randomized bench for flash_sprite_loader with a behavioural flash model.
// Latency: flash model pulses done 10 cycles after each observed start.
// Backpressure: fl_busy driven directly by the stimulus sequence.
module tb_flash_sprite_loader;
   import game_pkg::*;

   localparam int NB  = 4;
   localparam int AW  = 10;
   localparam int TO  = 20;
   localparam int LAT = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          load_req = 1'b0;
   logic [23:0]   load_addr = '0;
   logic          abort = 1'b0;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          loading;
   logic          load_done;
   logic          load_err;
   logic [AW:0]   bytes_loaded;

   flash_sprite_loader_if fl_bus();

   flash_sprite_loader #(
      .NUM_BYTES   (NB),
      .ADDR_W      (AW),
      .READ_CMD    (FLASH_CMD_READ),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_req     (load_req),
      .load_addr    (load_addr),
      .abort        (abort),
      .fl           (fl_bus.master),
      .wr_en        (wr_en),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .loading      (loading),
      .load_done    (load_done),
      .load_err     (load_err),
      .bytes_loaded (bytes_loaded)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_assert = 0;
   int n_fail   = 0;

   // ---------------- flash model: done LAT cycles after start, data = addr[7:0]^A5
   bit          no_done = 1'b0;
   bit          pend = 1'b0;
   int          cnt = 0;
   logic [23:0] paddr = '0;

   always @(negedge clk) begin
      fl_bus.fl_done = 1'b0;
      if (pend) begin
         cnt--;
         if (cnt == 0) begin
            fl_bus.fl_done     = 1'b1;
            fl_bus.fl_data_out = paddr[7:0] ^ 8'hA5;
            pend               = 1'b0;
         end
      end
      if (fl_bus.fl_start === 1'b1 && !no_done) begin
         pend  = 1'b1;
         cnt   = LAT;
         paddr = fl_bus.fl_addr;
      end
   end

   // ---------------- event log
   logic [23:0]   st_addr_q[$];
   logic [7:0]    st_cmd_q[$];
   int            st_cyc_q[$];
   logic [AW-1:0] wa_q[$];
   logic [7:0]    wd_q[$];
   int            done_cnt = 0;
   int            done_loading_bad = 0;
   int            err_cyc = -1;
   logic          err_prev = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (fl_bus.fl_start === 1'b1) begin
            st_addr_q.push_back(fl_bus.fl_addr);
            st_cmd_q.push_back(fl_bus.fl_cmd);
            st_cyc_q.push_back(cyc);
         end
         if (wr_en === 1'b1) begin
            wa_q.push_back(wr_addr);
            wd_q.push_back(wr_data);
         end
         if (load_done === 1'b1) begin
            done_cnt++;
            if (loading !== 1'b0) done_loading_bad++;
         end
         if (load_err === 1'b1 && err_prev !== 1'b1) err_cyc = cyc;
         err_prev = load_err;
      end
   end

   // ---------------- helpers
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      @(posedge clk);
      st_addr_q.delete();
      st_cmd_q.delete();
      st_cyc_q.delete();
      wa_q.delete();
      wd_q.delete();
      done_cnt = 0;
      done_loading_bad = 0;
      err_cyc = -1;
   endtask

   task automatic pulse_load(input logic [23:0] a);
      @(negedge clk);
      load_req  = 1'b1;
      load_addr = a;
      @(negedge clk);
      load_req  = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int i = 0;
      while (loading !== 1'b0 && i < 400) begin
         @(negedge clk);
         i++;
      end
      chk({tag, "/idle_wait_expired"}, 32'(i >= 400), 32'd0);
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_starts(input int n, input string tag);
      int i = 0;
      while (st_addr_q.size() < n && i < 200) begin
         @(negedge clk);
         i++;
      end
      chk({tag, "/start_wait_expired"}, 32'(i >= 200), 32'd0);
   endtask

   task automatic wait_writes(input int n, input string tag);
      int i = 0;
      while (wa_q.size() < n && i < 200) begin
         @(negedge clk);
         i++;
      end
      chk({tag, "/write_wait_expired"}, 32'(i >= 200), 32'd0);
   endtask

   // Reference: byte i of a load comes from (base+i) mod 2^24 and lands at RAM address i.
   task automatic check_load(input string tag, input logic [23:0] base);
      logic [31:0] ea;
      chk({tag, "/n_starts"}, 32'(st_addr_q.size()), 32'(NB));
      chk({tag, "/n_writes"}, 32'(wa_q.size()), 32'(NB));
      for (int i = 0; i < NB && i < st_addr_q.size(); i++) begin
         ea = ({8'h00, base} + 32'(i)) % 32'h0100_0000;
         chk($sformatf("%s/fl_addr%0d", tag, i), {8'h00, st_addr_q[i]}, ea);
         chk($sformatf("%s/fl_cmd%0d", tag, i), {24'h0, st_cmd_q[i]}, 32'h03);
      end
      for (int i = 0; i < NB && i < wa_q.size(); i++) begin
         ea = ({8'h00, base} + 32'(i)) % 32'h0100_0000;
         chk($sformatf("%s/wr_addr%0d", tag, i), 32'(wa_q[i]), 32'(i));
         chk($sformatf("%s/wr_data%0d", tag, i), {24'h0, wd_q[i]}, {24'h0, ea[7:0] ^ 8'hA5});
      end
      chk({tag, "/done_pulses"}, 32'(done_cnt), 32'd1);
      chk({tag, "/loading_on_done"}, 32'(done_loading_bad), 32'd0);
      chk({tag, "/bytes_loaded"}, 32'(bytes_loaded), 32'(NB));
      chk({tag, "/load_err"}, 32'(load_err), 32'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "/fl_start"},     32'(fl_bus.fl_start), 32'd0);
      chk({tag, "/fl_addr"},      32'(fl_bus.fl_addr), 32'd0);
      chk({tag, "/fl_cmd"},       32'(fl_bus.fl_cmd), 32'h03);
      chk({tag, "/fl_data_in"},   32'(fl_bus.fl_data_in), 32'd0);
      chk({tag, "/wr_en"},        32'(wr_en), 32'd0);
      chk({tag, "/wr_addr"},      32'(wr_addr), 32'd0);
      chk({tag, "/wr_data"},      32'(wr_data), 32'd0);
      chk({tag, "/loading"},      32'(loading), 32'd0);
      chk({tag, "/load_done"},    32'(load_done), 32'd0);
      chk({tag, "/load_err"},     32'(load_err), 32'd0);
      chk({tag, "/bytes_loaded"}, 32'(bytes_loaded), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus
   initial begin
      int          rel_cyc;
      logic [23:0] rb;

      fl_bus.fl_busy = 1'b0;

      // Reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // 1: basic load
      clear_log();
      pulse_load(24'h000100);
      chk("t1/loading_after_req", 32'(loading), 32'd1);
      wait_idle("t1");
      check_load("t1", 24'h000100);

      // 2: address wrap
      clear_log();
      pulse_load(24'hFFFFFE);
      wait_idle("t2");
      check_load("t2", 24'hFFFFFE);

      // 3: timeout
      clear_log();
      no_done = 1'b1;
      pulse_load(24'h000200);
      wait_idle("t3");
      chk("t3/load_err", 32'(load_err), 32'd1);
      chk("t3/n_starts", 32'(st_addr_q.size()), 32'd1);
      if (st_cyc_q.size() > 0)
         chk("t3/err_delay", 32'(err_cyc - st_cyc_q[0]), 32'(TO));
      chk("t3/n_writes", 32'(wa_q.size()), 32'd0);
      chk("t3/done_pulses", 32'(done_cnt), 32'd0);
      repeat (5) @(negedge clk);
      chk("t3/err_sticky", 32'(load_err), 32'd1);
      no_done = 1'b0;
      clear_log();
      pulse_load(24'h000300);
      chk("t3/err_cleared", 32'(load_err), 32'd0);
      chk("t3/loading_again", 32'(loading), 32'd1);
      wait_idle("t3b");
      check_load("t3b", 24'h000300);

      // 4: busy at second byte
      clear_log();
      pulse_load(24'h000400);
      wait_writes(1, "t4");
      fl_bus.fl_busy = 1'b1;
      repeat (5) @(negedge clk);
      chk("t4/no_start_while_busy", 32'(st_addr_q.size()), 32'd1);
      fl_bus.fl_busy = 1'b0;
      rel_cyc = cyc;
      wait_idle("t4");
      if (st_cyc_q.size() > 1)
         chk("t4/start_after_busy", 32'(st_cyc_q[1]), 32'(rel_cyc + 1));
      check_load("t4", 24'h000400);

      // 5: abort with a done still pending in the flash model
      clear_log();
      pulse_load(24'h000500);
      wait_writes(2, "t5");
      wait_starts(3, "t5");
      repeat (3) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      chk("t5/loading", 32'(loading), 32'd0);
      repeat (20) @(negedge clk);
      chk("t5/n_writes", 32'(wa_q.size()), 32'd2);
      chk("t5/n_starts", 32'(st_addr_q.size()), 32'd3);
      chk("t5/done_pulses", 32'(done_cnt), 32'd0);
      chk("t5/load_err", 32'(load_err), 32'd0);
      chk("t5/bytes_loaded", 32'(bytes_loaded), 32'd2);
      clear_log();
      pulse_load(24'h00ABCD);
      wait_idle("t5b");
      check_load("t5b", 24'h00ABCD);

      // 6: ignored load_req, then async reset mid-WAIT
      clear_log();
      pulse_load(24'h000600);
      wait_starts(1, "t6");
      pulse_load(24'h123456);
      wait_starts(2, "t6");
      if (st_addr_q.size() > 1) begin
         chk("t6/addr0", 32'(st_addr_q[0]), 32'h000600);
         chk("t6/addr1_ignores_req", 32'(st_addr_q[1]), 32'h000601);
      end
      repeat (2) @(negedge clk);
      chk("t6/loading_before_rst", 32'(loading), 32'd1);
      #2 rst_n = 1'b0;
      #1 check_reset_outputs("t6_async");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("t6/no_write_after_rst", 32'(wa_q.size()), 32'd1);
      chk("t6/loading_after_rst", 32'(loading), 32'd0);
      chk("t6/no_done_after_rst", 32'(done_cnt), 32'd0);
      clear_log();
      pulse_load(24'h000700);
      wait_idle("t6b");
      check_load("t6b", 24'h000700);

      // 7: random base addresses, biased toward the wrap point half the time
      for (int r = 0; r < 4; r++) begin
         rb = 24'($urandom);
         if ($urandom_range(0, 1) == 1) rb = 24'hFFFFFF - 24'($urandom_range(0, 3));
         repeat ($urandom_range(0, 5)) @(negedge clk);
         clear_log();
         pulse_load(rb);
         wait_idle($sformatf("rnd%0d", r));
         check_load($sformatf("rnd%0d", r), rb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
